// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types: register index and data word.
package cpu_types_pkg;
  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/wb_arbiter_pkg.sv
// Types and helpers shared by the write-back arbiter and its B-result FIFO.
package wb_arbiter_pkg;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic     live;
    regbits_t wsel;
    word_t    wdat;
  } wb_entry_t;

  localparam regbits_t REG_ZERO = '0;

  function automatic logic reg_hit(input logic live, input regbits_t wsel, input regbits_t sel);
    return live && (wsel == sel);
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for long-latency write results; every slot is visible to the
// parent so it can kill stale writes and answer busy queries.
module wb_fifo
  import cpu_types_pkg::*;
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  regbits_t                     push_wsel,
  input  word_t                        push_wdat,
  input  logic [DEPTH-1:0]             kill,
  output wb_entry_t [DEPTH-1:0]        entries,
  output logic [$clog2(DEPTH)-1:0]     head_idx,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t             wptr_q, wptr_d;
  ptr_t             rptr_q, rptr_d;
  logic [DEPTH-1:0] live_q, live_d;
  regbits_t         wsel_q [DEPTH];
  word_t            wdat_q [DEPTH];
  logic [AW-1:0]    widx, ridx;
  logic             push_ok, pop_ok;

  assign widx     = wptr_q[AW-1:0];
  assign ridx     = rptr_q[AW-1:0];
  assign head_idx = ridx;
  // Extra pointer MSB tells a full ring from an empty one.
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    live_d = live_q & ~kill;
    if (pop_ok) begin
      live_d[ridx] = 1'b0;
      rptr_d       = rptr_q + ptr_t'(1);
    end
    if (push_ok) begin
      live_d[widx] = 1'b1;
      wptr_d       = wptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      live_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      live_q <= live_d;
    end
  end

  // Payload is only meaningful under a set live bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      wsel_q[widx] <= push_wsel;
      wdat_q[widx] <= push_wdat;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign entries[i] = '{live: live_q[i], wsel: wsel_q[i], wdat: wdat_q[i]};
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline write-back (A, priority) with buffered long-latency results (B)
// onto the single register_file write port; tracks pending writes and starvation.
module wb_arbiter
  import cpu_types_pkg::*;
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        a_wen,
  input  logic [4:0]  a_wsel,
  input  logic [31:0] a_wdat,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_wsel,
  input  logic [31:0] b_wdat,
  output logic        rf_wen,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  input  logic [4:0]  query_sel1,
  input  logic [4:0]  query_sel2,
  output logic        busy1,
  output logic        busy2,
  output logic        stall_req
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t             head;
  logic [AW-1:0]         head_idx;
  logic                  full, empty;
  logic                  a_sel, head_live, push, pop;
  logic [DEPTH-1:0]      kill;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  stall_q, stall_d;

  assign a_sel     = a_wen && (a_wsel != REG_ZERO);
  assign head      = entries[head_idx];
  assign head_live = !empty && head.live;
  assign b_ready   = !full;
  // Writes to r0 complete the handshake but are never queued.
  assign push      = b_valid && !full && (b_wsel != REG_ZERO);
  // Dead heads drain every cycle; live heads wait for A to leave the port.
  assign pop       = !empty && (!head.live || !a_sel);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (nRST),
    .push      (push),
    .pop       (pop),
    .push_wsel (b_wsel),
    .push_wdat (b_wdat),
    .kill      (kill),
    .entries   (entries),
    .head_idx  (head_idx),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    rf_wen  = 1'b0;
    rf_wsel = '0;
    rf_wdat = '0;
    if (a_sel) begin
      rf_wen  = 1'b1;
      rf_wsel = a_wsel;
      rf_wdat = a_wdat;
    end else if (head_live) begin
      rf_wen  = 1'b1;
      rf_wsel = head.wsel;
      rf_wdat = head.wdat;
    end
  end

  // A is younger than anything already stored, so a matching A write makes it stale.
  always_comb begin
    kill  = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = a_sel && reg_hit(entries[i].live, entries[i].wsel, a_wsel);
      if ((query_sel1 != REG_ZERO) && reg_hit(entries[i].live, entries[i].wsel, query_sel1))
        busy1 = 1'b1;
      if ((query_sel2 != REG_ZERO) && reg_hit(entries[i].live, entries[i].wsel, query_sel2))
        busy2 = 1'b1;
    end
  end

  always_comb begin
    starve_d = '0;
    if (head_live && !pop)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + CW'(1);
    stall_d = (starve_d == STARVE_MAX);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_req = stall_q;
endmodule
